// File: rtl/mmio_ep_rx.sv
// Bulk-OUT endpoint receiver: decodes an 11-byte command frame and forwards the data phase.
// Define MMIO_EP_RX_MAGIC_EN to enforce the 'TART' magic in bytes 0-3.
module mmio_ep_rx #(
    parameter int LUNS      = 4,
    parameter int LEN_WIDTH = 16,
    localparam int LUN_BITS = (LUNS > 1) ? $clog2(LUNS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_conf_i,
    input  logic                 clr_conf_i,
    input  logic                 selected_i,
    input  logic                 rx_error_i,
    input  logic                 ack_sent_i,
    output logic                 ep_ready_o,
    output logic                 stalled_o,
    output logic                 parity_o,
    input  logic                 usb_tvalid_i,
    input  logic                 usb_tlast_i,
    input  logic [7:0]           usb_tdata_i,
    output logic                 usb_tready_o,
    output logic                 cmd_vld_o,
    input  logic                 cmd_ack_i,
    output logic                 cmd_dir_o,
    output logic                 cmd_apb_o,
    output logic [1:0]           cmd_cmd_o,
    output logic [3:0]           cmd_tag_o,
    output logic [LEN_WIDTH-1:0] cmd_len_o,
    output logic [LUN_BITS-1:0]  cmd_lun_o,
    output logic [27:0]          cmd_adr_o,
    output logic                 dat_tvalid_o,
    output logic                 dat_tlast_o,
    output logic [7:0]           dat_tdata_o,
    input  logic                 dat_tready_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        CMD   = 3'd2,
        WAIT  = 3'd3,
        DATA  = 3'd4,
        STALL = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [27:0]          adr_sh_q, adr_sh_d;
    logic [3:0]           lun_sh_q, lun_sh_d;
    logic [15:0]          len_sh_q, len_sh_d;
    logic                 magic_bad_q, magic_bad_d;
    logic                 pkt_open_q, pkt_open_d;
    logic                 parity_q, parity_d;
    logic [LEN_WIDTH-1:0] dcnt_q, dcnt_d;
    logic                 cmd_dir_q, cmd_dir_d;
    logic                 cmd_apb_q, cmd_apb_d;
    logic [1:0]           cmd_cmd_q, cmd_cmd_d;
    logic [3:0]           cmd_tag_q, cmd_tag_d;
    logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;
    logic [LUN_BITS-1:0]  cmd_lun_q, cmd_lun_d;
    logic [27:0]          cmd_adr_q, cmd_adr_d;

`ifdef MMIO_EP_RX_MAGIC_EN
    function automatic logic magic_mismatch(input logic [1:0] idx, input logic [7:0] b);
        logic [7:0] exp_b;
        case (idx)
            2'd0:    exp_b = 8'h54;
            2'd1:    exp_b = 8'h41;
            2'd2:    exp_b = 8'h52;
            default: exp_b = 8'h54;
        endcase
        return (b != exp_b);
    endfunction
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 4'd0;
            adr_sh_q    <= 28'd0;
            lun_sh_q    <= 4'd0;
            len_sh_q    <= 16'd0;
            magic_bad_q <= 1'b0;
            pkt_open_q  <= 1'b0;
            parity_q    <= 1'b0;
            dcnt_q      <= '0;
            cmd_dir_q   <= 1'b0;
            cmd_apb_q   <= 1'b0;
            cmd_cmd_q   <= 2'd0;
            cmd_tag_q   <= 4'd0;
            cmd_len_q   <= '0;
            cmd_lun_q   <= '0;
            cmd_adr_q   <= 28'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            adr_sh_q    <= adr_sh_d;
            lun_sh_q    <= lun_sh_d;
            len_sh_q    <= len_sh_d;
            magic_bad_q <= magic_bad_d;
            pkt_open_q  <= pkt_open_d;
            parity_q    <= parity_d;
            dcnt_q      <= dcnt_d;
            cmd_dir_q   <= cmd_dir_d;
            cmd_apb_q   <= cmd_apb_d;
            cmd_cmd_q   <= cmd_cmd_d;
            cmd_tag_q   <= cmd_tag_d;
            cmd_len_q   <= cmd_len_d;
            cmd_lun_q   <= cmd_lun_d;
            cmd_adr_q   <= cmd_adr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        adr_sh_d    = adr_sh_q;
        lun_sh_d    = lun_sh_q;
        len_sh_d    = len_sh_q;
        magic_bad_d = magic_bad_q;
        pkt_open_d  = pkt_open_q;
        dcnt_d      = dcnt_q;
        cmd_dir_d   = cmd_dir_q;
        cmd_apb_d   = cmd_apb_q;
        cmd_cmd_d   = cmd_cmd_q;
        cmd_tag_d   = cmd_tag_q;
        cmd_len_d   = cmd_len_q;
        cmd_lun_d   = cmd_lun_q;
        cmd_adr_d   = cmd_adr_q;
        parity_d    = parity_q ^ (ack_sent_i && selected_i && !rx_error_i && (state_q != STALL));

        case (state_q)
            IDLE: begin
                if (set_conf_i) state_d = READY;
            end
            READY: begin
                // A byte here while the previous data packet is still open is an over-run.
                if (usb_tvalid_i && pkt_open_q) begin
                    state_d = STALL;
                end else if (usb_tvalid_i && selected_i) begin
                    byte_cnt_d  = 4'd1;
                    adr_sh_d    = 28'd0;
                    lun_sh_d    = 4'd0;
                    len_sh_d    = 16'd0;
                    magic_bad_d = 1'b0;
`ifdef MMIO_EP_RX_MAGIC_EN
                    magic_bad_d = magic_mismatch(2'd0, usb_tdata_i);
`endif
                    state_d     = usb_tlast_i ? STALL : CMD;
                end else begin
                    state_d = READY;
                end
            end
            CMD: begin
                if (rx_error_i) begin
                    byte_cnt_d = 4'd0;
                    state_d    = READY;
                end else if (usb_tvalid_i) begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    case (byte_cnt_q)
`ifdef MMIO_EP_RX_MAGIC_EN
                        4'd1, 4'd2, 4'd3: magic_bad_d = magic_bad_q | magic_mismatch(byte_cnt_q[1:0], usb_tdata_i);
`endif
                        4'd4: adr_sh_d[7:0]   = usb_tdata_i;
                        4'd5: adr_sh_d[15:8]  = usb_tdata_i;
                        4'd6: adr_sh_d[23:16] = usb_tdata_i;
                        4'd7: begin
                            adr_sh_d[27:24] = usb_tdata_i[3:0];
                            lun_sh_d        = usb_tdata_i[7:4];
                        end
                        4'd8: len_sh_d[7:0] = usb_tdata_i;
                        4'd9: begin
                            if (LEN_WIDTH > 8) len_sh_d[15:8] = usb_tdata_i;
                            else len_sh_d[15:8] = 8'd0;
                        end
                        default: byte_cnt_d = byte_cnt_q + 4'd1;
                    endcase
                    if (byte_cnt_q == 4'd10) begin
                        if (!usb_tlast_i || magic_bad_q || ({28'd0, lun_sh_q} >= LUNS)) begin
                            state_d = STALL;
                        end else begin
                            cmd_apb_d = usb_tdata_i[3];
                            cmd_dir_d = usb_tdata_i[2];
                            cmd_cmd_d = usb_tdata_i[1:0];
                            cmd_tag_d = usb_tdata_i[7:4];
                            cmd_len_d = len_sh_q[LEN_WIDTH-1:0];
                            cmd_lun_d = lun_sh_q[LUN_BITS-1:0];
                            cmd_adr_d = adr_sh_q;
                            state_d   = WAIT;
                        end
                    end else if (usb_tlast_i) begin
                        state_d = STALL;
                    end else begin
                        state_d = CMD;
                    end
                end else begin
                    state_d = CMD;
                end
            end
            WAIT: begin
                if (cmd_ack_i) begin
                    dcnt_d  = '0;
                    state_d = cmd_dir_q ? READY : DATA;
                end else begin
                    state_d = WAIT;
                end
            end
            DATA: begin
                if (rx_error_i) begin
                    state_d = STALL;
                end else if (usb_tvalid_i && dat_tready_i) begin
                    if (dcnt_q == cmd_len_q) begin
                        pkt_open_d = !usb_tlast_i;
                        state_d    = READY;
                    end else begin
                        dcnt_d = dcnt_q + LEN_WIDTH'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STALL: state_d = STALL;
            default: state_d = IDLE;
        endcase

        if (clr_conf_i) begin
            state_d    = IDLE;
            pkt_open_d = 1'b0;
            byte_cnt_d = 4'd0;
        end
    end

    // Stream handshake: fixed in the command phase, pass-through in the data phase.
    always_comb begin
        usb_tready_o = 1'b0;
        dat_tvalid_o = 1'b0;
        dat_tdata_o  = 8'd0;
        dat_tlast_o  = 1'b0;
        case (state_q)
            READY, CMD: usb_tready_o = 1'b1;
            DATA: begin
                usb_tready_o = dat_tready_i;
                dat_tvalid_o = usb_tvalid_i;
                dat_tdata_o  = usb_tdata_i;
                dat_tlast_o  = usb_tvalid_i && (dcnt_q == cmd_len_q);
            end
            default: usb_tready_o = 1'b0;
        endcase
    end

    assign ep_ready_o = (state_q == READY);
    assign stalled_o  = (state_q == STALL);
    assign cmd_vld_o  = (state_q == WAIT);
    assign parity_o   = parity_q;
    assign cmd_dir_o  = cmd_dir_q;
    assign cmd_apb_o  = cmd_apb_q;
    assign cmd_cmd_o  = cmd_cmd_q;
    assign cmd_tag_o  = cmd_tag_q;
    assign cmd_len_o  = cmd_len_q;
    assign cmd_lun_o  = cmd_lun_q;
    assign cmd_adr_o  = cmd_adr_q;

endmodule

// File: tb/tb_mmio_ep_rx.sv
// Scoreboard bench for mmio_ep_rx: stimulus pushes expected commands/data, a monitor pops and compares.
module tb_mmio_ep_rx;
    logic        clock = 1'b0;
    logic        reset;
    logic        set_conf_i, clr_conf_i, selected_i, rx_error_i, ack_sent_i;
    logic        ep_ready_o, stalled_o, parity_o;
    logic        usb_tvalid_i, usb_tlast_i, usb_tready_o;
    logic [7:0]  usb_tdata_i;
    logic        cmd_vld_o, cmd_ack_i, cmd_dir_o, cmd_apb_o;
    logic [1:0]  cmd_cmd_o;
    logic [3:0]  cmd_tag_o;
    logic [15:0] cmd_len_o;
    logic [1:0]  cmd_lun_o;
    logic [27:0] cmd_adr_o;
    logic        dat_tvalid_o, dat_tlast_o, dat_tready_i;
    logic [7:0]  dat_tdata_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [53:0] cmd_exp_q[$];
    logic [8:0]  dat_exp_q[$];

    mmio_ep_rx #(.LUNS(4), .LEN_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .set_conf_i(set_conf_i), .clr_conf_i(clr_conf_i),
        .selected_i(selected_i), .rx_error_i(rx_error_i), .ack_sent_i(ack_sent_i),
        .ep_ready_o(ep_ready_o), .stalled_o(stalled_o), .parity_o(parity_o),
        .usb_tvalid_i(usb_tvalid_i), .usb_tlast_i(usb_tlast_i), .usb_tdata_i(usb_tdata_i),
        .usb_tready_o(usb_tready_o),
        .cmd_vld_o(cmd_vld_o), .cmd_ack_i(cmd_ack_i), .cmd_dir_o(cmd_dir_o), .cmd_apb_o(cmd_apb_o),
        .cmd_cmd_o(cmd_cmd_o), .cmd_tag_o(cmd_tag_o), .cmd_len_o(cmd_len_o),
        .cmd_lun_o(cmd_lun_o), .cmd_adr_o(cmd_adr_o),
        .dat_tvalid_o(dat_tvalid_o), .dat_tlast_o(dat_tlast_o), .dat_tdata_o(dat_tdata_o),
        .dat_tready_i(dat_tready_i)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitor: commands are compared every cycle they are offered (hold check) and popped on ack.
    always @(negedge clock) begin
        if (!reset) begin
            if (cmd_vld_o) begin
                if (cmd_exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_cmd: got cmd_vld_o=1 adr=%h required no command", cmd_adr_o);
                end else begin
                    chk("cmd_fields", {10'd0, cmd_dir_o, cmd_apb_o, cmd_cmd_o, cmd_tag_o, cmd_len_o,
                                       cmd_lun_o, cmd_adr_o}, {10'd0, cmd_exp_q[0]});
                    if (cmd_ack_i) void'(cmd_exp_q.pop_front());
                end
            end
            if (dat_tvalid_o && dat_tready_i) begin
                if (dat_exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_dat: got data %h last %b required no data", dat_tdata_o, dat_tlast_o);
                end else begin
                    chk("dat_beat", {55'd0, dat_tlast_o, dat_tdata_o}, {55'd0, dat_exp_q.pop_front()});
                end
            end
        end
    end

    task automatic exp_cmd(input logic dir, input logic apb, input logic [1:0] cmd, input logic [3:0] tag,
                           input logic [15:0] len, input logic [1:0] lun, input logic [27:0] adr);
        cmd_exp_q.push_back({dir, apb, cmd, tag, len, lun, adr});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        logic rdy;
        usb_tvalid_i = 1'b1;
        usb_tdata_i  = d;
        usb_tlast_i  = l;
        n = 0;
        do begin
            @(negedge clock);
            rdy = usb_tready_o;
            @(posedge clock);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("send_timeout", 64'd0, 64'd1);
        usb_tvalid_i = 1'b0;
        usb_tlast_i  = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] lun, input logic [27:0] adr, input logic [15:0] len,
                              input logic [3:0] tag, input logic [3:0] nib, input logic [7:0] m1,
                              input int early_idx, input int err_idx);
        logic [7:0] b[11];
        b = '{8'h54, m1, 8'h52, 8'h54, adr[7:0], adr[15:8], adr[23:16], {lun, adr[27:24]},
              len[7:0], len[15:8], {tag, nib}};
        for (int i = 0; i < 11; i++) begin
            rx_error_i = (i == err_idx);
            send_byte(b[i], (i == early_idx) || (i == 10));
            rx_error_i = 1'b0;
            if (i == early_idx || i == err_idx) break;
        end
    endtask

    task automatic do_ack(input int dly);
        int n = 0;
        while (!cmd_vld_o && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("cmd_vld_seen", cmd_vld_o, 1'b1);
        repeat (dly) @(posedge clock);
        #1;
        cmd_ack_i = 1'b1;
        @(posedge clock);
        #1;
        cmd_ack_i = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: set_conf_i = 1'b1;
            1: clr_conf_i = 1'b1;
            2: ack_sent_i = 1'b1;
            default: begin set_conf_i = 1'b1; clr_conf_i = 1'b1; end
        endcase
        @(posedge clock);
        #1;
        set_conf_i = 1'b0;
        clr_conf_i = 1'b0;
        ack_sent_i = 1'b0;
    endtask

    task automatic recover();
        pulse(1);
        chk("clr_stalled", stalled_o, 1'b0);
        chk("clr_ep_ready", ep_ready_o, 1'b0);
        pulse(0);
        chk("set_ep_ready", ep_ready_o, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; set_conf_i = 1'b0; clr_conf_i = 1'b0; selected_i = 1'b1;
        rx_error_i = 1'b0; ack_sent_i = 1'b0; usb_tvalid_i = 1'b0; usb_tlast_i = 1'b0;
        usb_tdata_i = 8'd0; cmd_ack_i = 1'b0; dat_tready_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ep_ready", ep_ready_o, 1'b0);
        chk("rst_stalled", stalled_o, 1'b0);
        chk("rst_parity", parity_o, 1'b0);
        chk("rst_cmd_vld", cmd_vld_o, 1'b0);
        chk("rst_tready", usb_tready_o, 1'b0);
        chk("rst_adr", cmd_adr_o, 28'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_tready", usb_tready_o, 1'b0);
        pulse(0);
        chk("ready_ep_ready", ep_ready_o, 1'b1);
        chk("ready_tready", usb_tready_o, 1'b1);

        // STORE, len 7: 8 data bytes, held command until a late ack
        exp_cmd(1'b0, 1'b0, 2'd0, 4'hA, 16'd7, 2'd0, 28'h0000800);
        send_frame(4'd0, 28'h0000800, 16'd7, 4'hA, 4'h0, 8'h41, 99, 99);
        chk("wait_tready", usb_tready_o, 1'b0);
        do_ack(3);
        for (int i = 0; i < 8; i++) begin
            dat_exp_q.push_back({(i == 7), 8'h10 + 8'(i)});
            send_byte(8'h10 + 8'(i), (i == 7));
        end
        chk("t1_ready", ep_ready_o, 1'b1);

        // FETCH, len 0: no data phase
        exp_cmd(1'b1, 1'b0, 2'd0, 4'h3, 16'd0, 2'd2, 28'h1234567);
        send_frame(4'd2, 28'h1234567, 16'd0, 4'h3, 4'h4, 8'h41, 99, 99);
        do_ack(0);
        chk("fetch_ready", ep_ready_o, 1'b1);
        exp_cmd(1'b1, 1'b1, 2'd2, 4'hF, 16'hFFFF, 2'd1, 28'hFFFFFFF);
        send_frame(4'd1, 28'hFFFFFFF, 16'hFFFF, 4'hF, 4'hE, 8'h41, 99, 99);
        do_ack(1);
        repeat (3) @(posedge clock);
        #1;
        chk("fetch2_ready", ep_ready_o, 1'b1);

        // len 129 over three packets with back-pressure and per-packet parity toggles
        exp_cmd(1'b0, 1'b0, 2'd0, 4'h1, 16'd129, 2'd3, 28'h0000040);
        send_frame(4'd3, 28'h0000040, 16'd129, 4'h1, 4'h0, 8'h41, 99, 99);
        pulse(2);
        chk("par_1", parity_o, 1'b1);
        do_ack(1);
        fork
            begin
                for (int i = 1; i <= 130; i++) begin
                    dat_exp_q.push_back({(i == 130), 8'h5A ^ 8'(i)});
                    send_byte(8'h5A ^ 8'(i), (i == 64) || (i == 128) || (i == 130));
                    if (i == 64)  begin pulse(2); chk("par_2", parity_o, 1'b0); end
                    if (i == 128) begin pulse(2); chk("par_3", parity_o, 1'b1); end
                    if (i == 130) begin pulse(2); chk("par_4", parity_o, 1'b0); end
                end
            end
            begin
                repeat (10) @(posedge clock);
                #1;
                dat_tready_i = 1'b0;
                repeat (4) @(posedge clock);
                #1;
                dat_tready_i = 1'b1;
            end
        join
        chk("long_ready", ep_ready_o, 1'b1);

        // rx_error at byte 6 discards the frame; resend decodes
        send_frame(4'd1, 28'h7777777, 16'd9, 4'h9, 4'h4, 8'h41, 99, 6);
        chk("err_ready", ep_ready_o, 1'b1);
        chk("err_parity", parity_o, 1'b0);
        chk("err_no_cmd", cmd_vld_o, 1'b0);
        exp_cmd(1'b0, 1'b0, 2'd0, 4'h5, 16'd2, 2'd3, 28'hABCDEF0);
        send_frame(4'd3, 28'hABCDEF0, 16'd2, 4'h5, 4'h0, 8'h41, 99, 99);
        do_ack(0);
        for (int i = 0; i < 3; i++) begin
            dat_exp_q.push_back({(i == 2), 8'hC0 + 8'(i)});
            send_byte(8'hC0 + 8'(i), (i == 2));
        end

        // magic 'TXRT'
`ifdef MMIO_EP_RX_MAGIC_EN
        send_frame(4'd0, 28'h0000123, 16'd0, 4'h2, 4'h5, 8'h58, 99, 99);
        chk("magic_stalled", stalled_o, 1'b1);
        chk("magic_tready", usb_tready_o, 1'b0);
        recover();
`else
        exp_cmd(1'b1, 1'b0, 2'd1, 4'h2, 16'd0, 2'd0, 28'h0000123);
        send_frame(4'd0, 28'h0000123, 16'd0, 4'h2, 4'h5, 8'h58, 99, 99);
        do_ack(0);
        chk("magic_ready", ep_ready_o, 1'b1);
`endif

        // lun out of range stalls until clr_conf; parity frozen in STALL
        send_frame(4'd5, 28'h0000001, 16'd0, 4'h1, 4'h4, 8'h41, 99, 99);
        chk("lun_stalled", stalled_o, 1'b1);
        chk("lun_tready", usb_tready_o, 1'b0);
        chk("lun_ep_ready", ep_ready_o, 1'b0);
        pulse(2);
        repeat (3) @(posedge clock);
        #1;
        chk("lun_parity", parity_o, 1'b0);
        chk("lun_still", stalled_o, 1'b1);
        recover();

        // tlast on byte 9
        send_frame(4'd0, 28'h0000002, 16'd0, 4'h1, 4'h4, 8'h41, 9, 99);
        chk("early_stalled", stalled_o, 1'b1);
        chk("early_tready", usb_tready_o, 1'b0);
        recover();

        // extra byte after the final data byte in the same packet
        exp_cmd(1'b0, 1'b0, 2'd0, 4'h6, 16'd1, 2'd0, 28'h0000010);
        send_frame(4'd0, 28'h0000010, 16'd1, 4'h6, 4'h0, 8'h41, 99, 99);
        do_ack(0);
        dat_exp_q.push_back({1'b0, 8'h01});
        dat_exp_q.push_back({1'b1, 8'h02});
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        chk("overrun_stalled", stalled_o, 1'b1);
        recover();

        // clr_conf beats a simultaneous set_conf
        pulse(3);
        chk("clr_wins", ep_ready_o, 1'b0);
        pulse(0);
        pulse(2);
        chk("par_pre_rst", parity_o, 1'b1);

        // reset in the middle of the data phase
        exp_cmd(1'b0, 1'b0, 2'd0, 4'h7, 16'd3, 2'd1, 28'h0000100);
        send_frame(4'd1, 28'h0000100, 16'd3, 4'h7, 4'h0, 8'h41, 99, 99);
        do_ack(0);
        dat_exp_q.push_back({1'b0, 8'hE0});
        dat_exp_q.push_back({1'b0, 8'hE1});
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        usb_tvalid_i = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_dat", dat_tvalid_o, 1'b0);
        chk("mid_rst_tready", usb_tready_o, 1'b0);
        chk("mid_rst_parity", parity_o, 1'b0);
        chk("mid_rst_len", cmd_len_o, 16'd0);
        chk("mid_rst_ep", ep_ready_o, 1'b0);
        usb_tvalid_i = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("cmd_q_empty", cmd_exp_q.size(), 0);
        chk("dat_q_empty", dat_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
